// File: rtl/axis_fir_rx.sv
// AXI4-Stream sink for the FIR output: throttled tready, per-frame statistics
// (count, signed max/min, zero crossings, tkeep errors) published at each tlast.
module axis_fir_rx #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned THROTTLE_PERIOD = 16,
    parameter int unsigned THROTTLE_OFF    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [3:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              stat_valid,
    input  logic              stat_ready,
    output logic [CNT_W-1:0]  stat_count,
    output logic [DATA_W-1:0] stat_max,
    output logic [DATA_W-1:0] stat_min,
    output logic [CNT_W-1:0]  stat_zc,
    output logic              stat_keep_err,
    output logic              busy
);

    // Counter is one bit wider than strictly needed so PERIOD-OFF always fits.
    localparam int unsigned THR_W = $clog2(THROTTLE_PERIOD + 1);
    localparam logic [THR_W-1:0] THR_LAST = THR_W'(THROTTLE_PERIOD - 1);
    localparam logic [THR_W-1:0] THR_ON   = THR_W'(THROTTLE_PERIOD - THROTTLE_OFF);
    localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [THR_W-1:0]   r_thr;
    logic [THR_W-1:0]   w_thr_nxt;
    logic               r_tready;
    logic               r_stat_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_max;
    logic [DATA_W-1:0]  r_min;
    logic [CNT_W-1:0]   r_zc;
    logic               r_keep_err;
    logic               r_prev_sign;

    logic               w_accept;
    logic               w_done;
    logic               w_first;
    logic               w_sign;

    assign w_accept = s_axis_tvalid & r_tready;
    assign w_done   = r_stat_valid & stat_ready;
    assign w_first  = (r_count == '0);
    assign w_sign   = s_axis_tdata[DATA_W-1];

    // Next-state and throttle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_thr_nxt   = r_thr;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_RECV;
                    w_thr_nxt   = '0;
                end
            end
            ST_RECV: begin
                w_thr_nxt = (r_thr == THR_LAST) ? '0 : r_thr + THR_W'(1);
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (stat_ready) begin
                    w_state_nxt = enable ? ST_RECV : ST_IDLE;
                    w_thr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_thr_nxt   = '0;
            end
        endcase
    end

    // State, registered handshake outputs and frame accumulators.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_thr        <= '0;
            r_tready     <= 1'b0;
            r_stat_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_max        <= MAX_INIT;
            r_min        <= MIN_INIT;
            r_zc         <= '0;
            r_keep_err   <= 1'b0;
            r_prev_sign  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_thr        <= w_thr_nxt;
            r_tready     <= (w_state_nxt == ST_RECV) && (w_thr_nxt < THR_ON);
            r_stat_valid <= (w_state_nxt == ST_REPORT);
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_done) begin
                r_count     <= '0;
                r_max       <= MAX_INIT;
                r_min       <= MIN_INIT;
                r_zc        <= '0;
                r_keep_err  <= 1'b0;
                r_prev_sign <= 1'b0;
            end else if (w_accept) begin
                if (r_count != '1) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_first) begin
                    r_max <= s_axis_tdata;
                    r_min <= s_axis_tdata;
                end else begin
                    if ($signed(s_axis_tdata) > $signed(r_max)) begin
                        r_max <= s_axis_tdata;
                    end
                    if ($signed(s_axis_tdata) < $signed(r_min)) begin
                        r_min <= s_axis_tdata;
                    end
                    if ((w_sign != r_prev_sign) && (r_zc != '1)) begin
                        r_zc <= r_zc + CNT_W'(1);
                    end
                end
                r_prev_sign <= w_sign;
                r_keep_err  <= r_keep_err | (s_axis_tkeep != 4'hF);
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign stat_valid    = r_stat_valid;
    assign busy          = r_busy;
    assign stat_count    = r_count;
    assign stat_max      = r_max;
    assign stat_min      = r_min;
    assign stat_zc       = r_zc;
    assign stat_keep_err = r_keep_err;

endmodule

// File: tb/tb_axis_fir_rx.sv
// Directed + randomized bench for axis_fir_rx; expected statistics come from
// a frame-level model computed over the list of beats actually sent.
module tb_axis_fir_rx;

    localparam int unsigned PERIOD = 4;
    localparam int unsigned OFF    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        stat_valid;
    logic        stat_ready;
    logic [15:0] stat_count;
    logic [31:0] stat_max;
    logic [31:0] stat_min;
    logic [15:0] stat_zc;
    logic        stat_keep_err;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] tx_d[$];
    logic [3:0]  tx_k[$];

    axis_fir_rx #(
        .DATA_W(32), .CNT_W(16), .THROTTLE_PERIOD(PERIOD), .THROTTLE_OFF(OFF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .stat_valid(stat_valid),
        .stat_ready(stat_ready), .stat_count(stat_count), .stat_max(stat_max),
        .stat_min(stat_min), .stat_zc(stat_zc), .stat_keep_err(stat_keep_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive beats lo..hi of tx_d/tx_k, waiting for tready on each one.
    task automatic send_beats(input int lo, input int hi);
        logic acc;
        int   guard;
        for (int i = lo; i <= hi; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_d[i];
            s_axis_tkeep  = tx_k[i];
            s_axis_tlast  = (i == tx_d.size() - 1);
            guard = 0;
            forever begin
                acc = s_axis_tready;
                tick();
                if (acc) break;
                guard++;
                if (guard > 100) begin
                    n_chk++;
                    n_err++;
                    $error("FAIL beat_timeout observed=stalled expected=accepted beat %0d", i);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Frame statistics derived directly from the beat list.
    task automatic check_stats(input string tag);
        logic signed [31:0] mx, mn;
        int zc;
        bit ke;
        mx = tx_d[0];
        mn = tx_d[0];
        zc = 0;
        ke = 1'b0;
        foreach (tx_d[i]) begin
            if ($signed(tx_d[i]) > mx) mx = tx_d[i];
            if ($signed(tx_d[i]) < mn) mn = tx_d[i];
            if (i > 0 && tx_d[i][31] != tx_d[i-1][31]) zc++;
            if (tx_k[i] != 4'hF) ke = 1'b1;
        end
        check({tag, "_valid"}, 32'(stat_valid), 32'd1);
        check({tag, "_count"}, 32'(stat_count), 32'(tx_d.size()));
        check({tag, "_max"}, stat_max, mx);
        check({tag, "_min"}, stat_min, mn);
        check({tag, "_zc"}, 32'(stat_zc), 32'(zc));
        check({tag, "_keep_err"}, 32'(stat_keep_err), 32'(ke));
    endtask

    task automatic consume(input logic en);
        enable     = en;
        stat_ready = 1'b1;
        tick();
        stat_ready = 1'b0;
        check("consume_valid", 32'(stat_valid), 32'd0);
        check("consume_count_clr", 32'(stat_count), 32'd0);
        check("consume_busy", 32'(busy), 32'(en));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_svalid"}, 32'(stat_valid), 32'd0);
        check({tag, "_count"}, 32'(stat_count), 32'd0);
        check({tag, "_max"}, stat_max, 32'h8000_0000);
        check({tag, "_min"}, stat_min, 32'h7FFF_FFFF);
        check({tag, "_zc"}, 32'(stat_zc), 32'd0);
        check({tag, "_kerr"}, 32'(stat_keep_err), 32'd0);
    endtask

    initial begin
        int acc_n;
        int len;
        logic [15:0] held_cnt;
        logic [31:0] held_max;

        reset = 1'b0; enable = 1'b0; stat_ready = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        tick(); tick();
        check_reset("reset");
        reset = 1'b1;

        // Disabled receiver ignores offered beats.
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h1234_5678;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("disabled_tready", 32'(s_axis_tready), 32'd0);
            check("disabled_busy", 32'(busy), 32'd0);
        end
        s_axis_tvalid = 1'b0;
        enable = 1'b1;
        tx_d = '{32'hFFFF_FFFF}; tx_k = '{4'hF};
        send_beats(0, 0);
        check_stats("single");
        consume(1'b1);

        // Mixed-sign four-beat frame.
        tx_d = '{32'h10, 32'hFFFF_FFE0, 32'h30, 32'h5}; tx_k = '{4'hF, 4'hF, 4'hF, 4'hF};
        send_beats(0, 3);
        check_stats("basic");
        check("basic_zc_const", 32'(stat_zc), 32'd2);
        check("basic_min_const", stat_min, 32'hFFFF_FFE0);
        consume(1'b1);

        // Backpressure on the stat port holds the record and stalls input.
        tx_d = '{32'h100, 32'hFFFF_0000, 32'h7}; tx_k = '{4'hF, 4'hF, 4'hF};
        send_beats(0, 2);
        check_stats("hold");
        held_cnt = stat_count;
        held_max = stat_max;
        tx_d = '{32'hAAAA, 32'h55, 32'hFFFF_FFF0}; tx_k = '{4'hF, 4'hF, 4'hF};
        s_axis_tvalid = 1'b1; s_axis_tdata = tx_d[0]; s_axis_tkeep = 4'hF;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_valid", 32'(stat_valid), 32'd1);
            check("hold_tready", 32'(s_axis_tready), 32'd0);
            check("hold_count", 32'(stat_count), 32'(held_cnt));
            check("hold_max", stat_max, held_max);
        end
        consume(1'b1);
        send_beats(0, 0);
        check("next_first_count", 32'(stat_count), 32'd1);
        send_beats(1, 2);
        check_stats("after_hold");
        consume(1'b1);

        // tkeep error flags the frame and clears for the next one.
        tx_d = '{32'h1, 32'h2, 32'h3}; tx_k = '{4'hF, 4'h3, 4'hF};
        send_beats(0, 2);
        check_stats("keep_bad");
        consume(1'b1);
        tx_d = '{32'h4, 32'h5, 32'h6}; tx_k = '{4'hF, 4'hF, 4'hF};
        send_beats(0, 2);
        check_stats("keep_ok");
        consume(1'b1);

        // Reset mid-frame discards partial accumulation.
        tx_d = '{32'hFFFF_FF00, 32'h40, 32'h1}; tx_k = '{4'hF, 4'hF, 4'hF};
        send_beats(0, 1);
        reset = 1'b0;
        tick();
        check_reset("midreset");
        reset = 1'b1;
        tx_d = '{32'h7, 32'h8}; tx_k = '{4'hF, 4'hF};
        send_beats(0, 1);
        check_stats("post_reset");
        consume(1'b0);

        // Throttle window: ready (i mod PERIOD) < PERIOD-OFF from RECV entry.
        tx_d.delete(); tx_k.delete();
        for (int i = 0; i < 12; i++) begin
            tx_d.push_back($urandom());
            tx_k.push_back(4'hF);
        end
        enable = 1'b1;
        tick();
        acc_n = 0;
        for (int c = 0; c < 16; c++) begin
            check("thr_tready", 32'(s_axis_tready), 32'((c % PERIOD) < (PERIOD - OFF)));
            if (acc_n < 12) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = tx_d[acc_n];
                s_axis_tkeep  = 4'hF;
                s_axis_tlast  = (acc_n == 11);
                if (s_axis_tready) acc_n++;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("thr_accepted", 32'(acc_n), 32'd12);
        check_stats("thr");
        consume(1'b1);

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 8);
            tx_d.delete(); tx_k.delete();
            for (int i = 0; i < len; i++) begin
                tx_d.push_back($urandom());
                tx_k.push_back(($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF);
            end
            send_beats(0, len - 1);
            check_stats("rand");
            repeat ($urandom_range(0, 3)) tick();
            consume(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
